uart_tx_fifo: RTL

Parametrised next-generation UART transmitter for the acquisition datapath. It sits between byte producers (flash readout, sample packer) and the RS232 pin.
- Accepts words over a valid/ready handshake into an internal FIFO.
- Serialises each word as start, data LSB-first, optional parity, and 1 or 2 stop bits, with a compile-time baud divisor.
- Frames are sent back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo_sync_fifo.sv | 46 ++++
 rtl/uart_tx_fifo.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity codes and baud divisor helper for the UART paths.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounded to the nearest whole clock count per bit.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with an explicit occupancy count separating full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  assign dout  = mem[rd_ptr];
  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter; start, LSB-first data, optional parity, 1-2 stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [LW-1:0]        fifo_level,
  output logic                 tx_busy,
  output logic                 rs232_tx
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);

  if (DIV < 4) begin : g_div_chk
    $error("uart_tx_fifo: DIV must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bits;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 par;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 bit_end;
  logic                 data_last;
  logic                 stop_last;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (tx_data),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty),
    .level(fifo_level)
  );

  assign push      = tx_valid && tx_ready;
  assign bit_end   = cnt == CW'(DIV - 1);
  assign data_last = bits == 4'(DATA_BITS - 1);
  assign stop_last = bits == 4'(STOP_BITS - 1);
  assign pop       = !empty && (state == IDLE || (state == STOP && bit_end && stop_last));
  assign tx_busy   = state != IDLE || fifo_level != '0;

  // tx_ready is registered from the next occupancy so a push can never land on a full FIFO.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bits     <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx_ready <= 1'b0;
      rs232_tx <= 1'b1;
    end else begin
      tx_ready <= !((full || (fifo_level == LW'(FIFO_DEPTH - 1) && push)) && !pop);
      rs232_tx <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PAR ? par : 1'b1;
      cnt      <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      if (pop) begin
        state <= START;
        shift <= head;
        bits  <= '0;
        par   <= PARITY == PAR_ODD ? ~^head : ^head;
      end else if (bit_end)
        case (state)
          START: state <= DATA;
          DATA: begin
            shift <= shift >> 1;
            bits  <= data_last ? '0 : bits + 1'b1;
            if (data_last) state <= PARITY == PAR_NONE ? STOP : PAR;
          end
          PAR: state <= STOP;
          STOP: begin
            bits <= bits + 1'b1;
            if (stop_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end

endmodule
